// File: rtl/ob_lm_table_cnt_acc.sv
// Frame accumulator: N words per beat folded into a carry-save S/C pair, resolved once per frame.
// Optional build macro OB_LM_TABLE_CNT_ACC_SAT_EN saturates out_sum to all-ones on overflow.
module ob_lm_table_cnt_acc #(
  parameter int W  = 32,
  parameter int N  = 8,
  parameter int G  = 8,
  parameter int BW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic [N-1:0][W-1:0] in_x,
  input  logic                in_last,
  output logic                in_rdy,
  output logic                out_vld,
  output logic [W-1:0]        out_sum,
  output logic                out_ovf,
  output logic [BW-1:0]       out_beats,
  input  logic                out_accept
);

  localparam int AW = W + G;

  typedef enum logic [1:0] {IDLE, ACC, RESOLVE, DONE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_s;
  logic [AW-1:0] r_c;
  logic [BW-1:0] r_cnt;
  logic          r_in_rdy;
  logic          r_out_vld;
  logic [W-1:0]  r_out_sum;
  logic          r_out_ovf;
  logic [BW-1:0] r_out_beats;

  logic [AW-1:0] w_s [0:N];
  logic [AW-1:0] w_c [0:N];
  logic          w_accept;
  logic [AW-1:0] w_res;
  logic          w_ovf;
  logic [W-1:0]  w_sum;
  logic [BW-1:0] w_cnt_inc;

  // Each stage is a 3:2 compressor folding one zero-extended word into the running (S, C) pair.
  assign w_s[0] = r_s;
  assign w_c[0] = r_c;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_csa
      logic [AW-1:0] w_x;
      assign w_x        = {{G{1'b0}}, in_x[gi]};
      assign w_s[gi+1]  = w_s[gi] ^ w_c[gi] ^ w_x;
      assign w_c[gi+1]  = ((w_s[gi] & w_c[gi]) | (w_s[gi] & w_x) | (w_c[gi] & w_x)) << 1;
    end
  endgenerate

  assign w_accept  = in_vld & r_in_rdy;
  assign w_res     = r_s + r_c;
  assign w_ovf     = |w_res[AW-1:W];
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + BW'(1);

`ifdef OB_LM_TABLE_CNT_ACC_SAT_EN
  assign w_sum = w_ovf ? {W{1'b1}} : w_res[W-1:0];
`else
  assign w_sum = w_res[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_c         <= '0;
      r_cnt       <= '0;
      r_in_rdy    <= 1'b1;
      r_out_vld   <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_beats <= '0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          if (w_accept) begin
            r_s   <= w_s[N];
            r_c   <= w_c[N];
            r_cnt <= w_cnt_inc;
            if (in_last) begin
              r_state  <= RESOLVE;
              r_in_rdy <= 1'b0;
            end else begin
              r_state  <= ACC;
            end
          end
        end
        RESOLVE: begin
          // The only carry-propagate add, taken once per frame.
          r_out_sum   <= w_sum;
          r_out_ovf   <= w_ovf;
          r_out_beats <= r_cnt;
          r_out_vld   <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_accept) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_c         <= '0;
            r_cnt       <= '0;
            r_in_rdy    <= 1'b1;
            r_out_vld   <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_beats <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_rdy    = r_in_rdy;
  assign out_vld   = r_out_vld;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign out_beats = r_out_beats;

endmodule

// File: tb/tb_ob_lm_table_cnt_acc.sv
// Directed bench for ob_lm_table_cnt_acc; BW is narrowed so beat-count saturation is reachable.
module tb_ob_lm_table_cnt_acc;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int G  = 8;
  localparam int BW = 4;

`ifdef OB_LM_TABLE_CNT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic [N-1:0][W-1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  beat_t         in_x;
  logic          in_last;
  logic          in_rdy;
  logic          out_vld;
  logic [W-1:0]  out_sum;
  logic          out_ovf;
  logic [BW-1:0] out_beats;
  logic          out_accept;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ob_lm_table_cnt_acc #(.W(W), .N(N), .G(G), .BW(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_x       (in_x),
    .in_last    (in_last),
    .in_rdy     (in_rdy),
    .out_vld    (out_vld),
    .out_sum    (out_sum),
    .out_ovf    (out_ovf),
    .out_beats  (out_beats),
    .out_accept (out_accept)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t fill(input logic [W-1:0] v);
    beat_t b;
    for (int k = 0; k < N; k++) b[k] = v;
    return b;
  endfunction

  // Expected out_sum from a (W+G)-bit true sum, honouring the saturating build.
  function automatic logic [W-1:0] exp_sum(input logic [W+G-1:0] r);
    if (SAT && (r[W+G-1:W] != '0)) return {W{1'b1}};
    return r[W-1:0];
  endfunction

  task automatic put(input beat_t x, input logic last);
    int n = 0;
    in_vld  = 1'b1;
    in_x    = x;
    in_last = last;
    while (in_rdy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("put_rdy", {63'b0, in_rdy}, 64'd1);
    tick();
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (out_vld !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("done_vld", {63'b0, out_vld}, 64'd1);
  endtask

  task automatic take();
    out_accept = 1'b1;
    tick();
    out_accept = 1'b0;
    chk("take_vld", {63'b0, out_vld}, 64'd0);
    chk("take_sum", {32'b0, out_sum}, 64'd0);
  endtask

  initial begin
    beat_t             b;
    logic [W+G-1:0]    model;
    logic [BW-1:0]     mcnt;
    int                nb;

    rst = 1'b1; in_vld = 1'b0; in_x = '0; in_last = 1'b0; out_accept = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rdy",   {63'b0, in_rdy},    64'd1);
    chk("rst_vld",   {63'b0, out_vld},   64'd0);
    chk("rst_sum",   {32'b0, out_sum},   64'd0);
    chk("rst_ovf",   {63'b0, out_ovf},   64'd0);
    chk("rst_beats", {60'b0, out_beats}, 64'd0);

    // Single beat 1..8: accepted at this edge, out_vld seen at the second edge after.
    for (int k = 0; k < N; k++) b[k] = W'(k + 1);
    in_vld = 1'b1; in_x = b; in_last = 1'b1;
    tick();
    in_vld = 1'b0; in_last = 1'b0;
    chk("lat_rdy",   {63'b0, in_rdy},    64'd0);
    chk("lat_vld1",  {63'b0, out_vld},   64'd0);
    tick();
    chk("lat_vld2",  {63'b0, out_vld},   64'd1);
    chk("one_sum",   {32'b0, out_sum},   64'd36);
    chk("one_ovf",   {63'b0, out_ovf},   64'd0);
    chk("one_beats", {60'b0, out_beats}, 64'd1);
    take();
    chk("idle_rdy",  {63'b0, in_rdy},    64'd1);

    // Three beats of 8 x 0x2000_0000: true sum 0x3_0000_0000.
    put(fill(32'h2000_0000), 1'b0);
    put(fill(32'h2000_0000), 1'b0);
    put(fill(32'h2000_0000), 1'b1);
    wait_done();
    chk("ovf3_sum",   {32'b0, out_sum},   {32'b0, exp_sum(40'h03_0000_0000)});
    chk("ovf3_ovf",   {63'b0, out_ovf},   64'd1);
    chk("ovf3_beats", {60'b0, out_beats}, 64'd3);

    // Consumer stall with a beat pending: nothing absorbed, outputs frozen.
    in_vld = 1'b1; in_x = fill(32'hFFFF_FFFF); in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rdy",   {63'b0, in_rdy},    64'd0);
      chk("stall_vld",   {63'b0, out_vld},   64'd1);
      chk("stall_sum",   {32'b0, out_sum},   {32'b0, exp_sum(40'h03_0000_0000)});
      chk("stall_beats", {60'b0, out_beats}, 64'd3);
    end
    out_accept = 1'b1;
    tick();
    out_accept = 1'b0;
    in_vld = 1'b0; in_last = 1'b0;
    chk("stall_rel", {63'b0, out_vld}, 64'd0);
    put(fill(32'd5), 1'b1);
    wait_done();
    chk("fresh_sum",   {32'b0, out_sum},   64'd40);
    chk("fresh_ovf",   {63'b0, out_ovf},   64'd0);
    chk("fresh_beats", {60'b0, out_beats}, 64'd1);
    take();

    // Reset mid-frame discards the partial sum.
    put(fill(32'd7), 1'b0);
    put(fill(32'd7), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rdy",   {63'b0, in_rdy},    64'd1);
    chk("mid_vld",   {63'b0, out_vld},   64'd0);
    put(fill(32'hFFFF_FFFF), 1'b1);
    wait_done();
    chk("mid_sum",   {32'b0, out_sum},   {32'b0, exp_sum(40'h07_FFFF_FFF8)});
    chk("mid_ovf",   {63'b0, out_ovf},   64'd1);
    chk("mid_beats", {60'b0, out_beats}, 64'd1);

    // Reset in DONE wins over a concurrent out_accept.
    rst = 1'b1; out_accept = 1'b1;
    tick();
    rst = 1'b0; out_accept = 1'b0;
    chk("rdone_vld", {63'b0, out_vld},   64'd0);
    chk("rdone_rdy", {63'b0, in_rdy},    64'd1);
    chk("rdone_sum", {32'b0, out_sum},   64'd0);

    // 20 beats of ones: count saturates at 2^BW-1 = 15.
    for (int i = 0; i < 20; i++) put(fill(32'd1), (i == 19) ? 1'b1 : 1'b0);
    wait_done();
    chk("satc_sum",   {32'b0, out_sum},   64'd160);
    chk("satc_beats", {60'b0, out_beats}, 64'd15);
    take();

    // Random frames against a (W+G)-bit scoreboard.
    for (int f = 0; f < 6; f++) begin
      nb    = int'($urandom_range(1, 40));
      model = '0;
      mcnt  = '0;
      for (int i = 0; i < nb; i++) begin
        for (int k = 0; k < N; k++) begin
          b[k]  = $urandom >> $urandom_range(0, 31);
          model = model + {{G{1'b0}}, b[k]};
        end
        if (mcnt != {BW{1'b1}}) mcnt = mcnt + 1'b1;
        put(b, (i == nb - 1) ? 1'b1 : 1'b0);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_done();
      repeat ($urandom_range(0, 3)) tick();
      chk("rnd_sum",   {32'b0, out_sum},   {32'b0, exp_sum(model)});
      chk("rnd_ovf",   {63'b0, out_ovf},   {63'b0, (model[W+G-1:W] != '0)});
      chk("rnd_beats", {60'b0, out_beats}, {60'b0, mcnt});
      take();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
